// File: rtl/codificador8x3_seq_pkg.sv
// Shared types and constants for the sequential 8-to-3 encoder.
// Line count, code width, FSM states and a one-hot helper live here.
package codificador_pkg;

  localparam int N_LINHAS = 8;
  localparam int W_CODE   = 3;

  typedef enum logic {
    OCIOSO,
    APRESENTA
  } estado_t;

  // Turns a line index into a mask with only that line set
  function automatic logic [N_LINHAS-1:0] one_hot(input logic [W_CODE-1:0] idx);
    return N_LINHAS'(1) << idx;
  endfunction

endpackage

// File: rtl/codificador8x3_seq_if.sv
// Event and handshake bus of the sequential 8-to-3 encoder.
// The encoder is the master: it receives event lines, clear and ready,
// and drives code, valid, pending and overflow.
interface codificador8x3_seq_if;
  import codificador_pkg::*;

  logic [N_LINHAS-1:0] e;
  logic                clear;
  logic [W_CODE-1:0]   code;
  logic                valid;
  logic                ready;
  logic [N_LINHAS-1:0] pending;
  logic                overflow;

  modport master (
    input  e, clear, ready,
    output code, valid, pending, overflow
  );

  modport slave (
    output e, clear, ready,
    input  code, valid, pending, overflow
  );

endinterface

// File: rtl/codificador8x3_seq_enc.sv
// Combinational priority encoder: returns the highest set index of mask.
// found is low when mask is empty, and code is then 0.
module codificador8x3
  import codificador_pkg::*;
(
  input  logic [N_LINHAS-1:0] mask,
  output logic [W_CODE-1:0]   code,
  output logic                found
);

  // Scanning upward lets the highest set bit be the last one written
  always_comb begin
    code  = '0;
    found = |mask;
    for (int i = 0; i < N_LINHAS; i++) begin
      if (mask[i]) code = W_CODE'(i);
    end
  end

endmodule

// File: rtl/codificador8x3_seq.sv
// Sequential 8-to-3 encoder: captures rising edges on the event lines as
// pending requests and hands their indices out one per valid/ready transfer.
// RR=0 gives fixed priority (highest index), RR=1 gives round-robin.
module codificador8x3_seq
  import codificador_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input logic clk,
  input logic rst_n,
  codificador8x3_seq_if.master bus
);

  logic [N_LINHAS-1:0] prev;
  logic [N_LINHAS-1:0] pending_q;
  logic [N_LINHAS-1:0] rise;
  logic [N_LINHAS-1:0] taken;
  logic [N_LINHAS-1:0] remaining;
  logic [N_LINHAS-1:0] rotated;
  logic [W_CODE-1:0]   code_q;
  logic [W_CODE-1:0]   ptr;
  logic [W_CODE-1:0]   ptr_next;
  logic [W_CODE-1:0]   off;
  logic [W_CODE-1:0]   enc_code;
  logic [W_CODE-1:0]   sel;
  logic                valid_q;
  logic                overflow_q;
  logic                found;
  estado_t             estado;

  // Edge detect, transfer bookkeeping and the rotated search window.
  // The search starts at off and goes downward; rotating the mask so that
  // bit off lands on the top bit turns that into a plain priority encode.
  // Fixed priority is just the window that starts at the top line.
  always_comb begin
    rise      = bus.e & ~prev;
    taken     = (valid_q && bus.ready) ? one_hot(code_q) : '0;
    remaining = pending_q & ~taken;
    ptr_next  = (valid_q && bus.ready) ? code_q - W_CODE'(1) : ptr;
    off       = RR ? ptr_next : '1;
    rotated   = '0;
    for (int j = 0; j < N_LINHAS; j++) begin
      rotated[j] = remaining[W_CODE'(j + int'(off) + 1)];
    end
    sel = enc_code + off + W_CODE'(1);
  end

  codificador8x3 u_enc (
    .mask  (rotated),
    .code  (enc_code),
    .found (found)
  );

  // Edge history, pending bitmap, overflow pulse, round-robin pointer and
  // the presentation FSM, all registered together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '1;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      ptr        <= '1;
      estado     <= OCIOSO;
    end else begin
      prev <= bus.e;
      if (bus.clear) begin
        pending_q  <= '0;
        code_q     <= '0;
        valid_q    <= 1'b0;
        overflow_q <= 1'b0;
        estado     <= OCIOSO;
      end else begin
        pending_q  <= remaining | rise;
        overflow_q <= |(rise & remaining);
        ptr        <= ptr_next;
        case (estado)
          OCIOSO: begin
            if (found) begin
              code_q  <= sel;
              valid_q <= 1'b1;
              estado  <= APRESENTA;
            end
          end
          APRESENTA: begin
            if (bus.ready) begin
              if (found) begin
                code_q <= sel;
              end else begin
                code_q  <= '0;
                valid_q <= 1'b0;
                estado  <= OCIOSO;
              end
            end
          end
          default: begin
            code_q  <= '0;
            valid_q <= 1'b0;
            estado  <= OCIOSO;
          end
        endcase
      end
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = valid_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_codificador8x3_seq.sv
// Directed bench for codificador8x3_seq: a fixed-priority and a round-robin
// instance receive identical stimulus and are compared against hand-worked
// expected values after every clock edge.
module tb_codificador8x3_seq;
  import codificador_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  codificador8x3_seq_if bus_fix ();
  codificador8x3_seq_if bus_rr ();

  codificador8x3_seq #(.RR(1'b0)) dut_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fix)
  );

  codificador8x3_seq #(.RR(1'b1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the same inputs onto both instances
  task automatic applyStimulus(input logic [7:0] ev, input logic rdy, input logic clr);
    bus_fix.e     = ev;
    bus_fix.ready = rdy;
    bus_fix.clear = clr;
    bus_rr.e      = ev;
    bus_rr.ready  = rdy;
    bus_rr.clear  = clr;
  endtask

  // Single point where every comparison is counted and reported
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Full output state of both instances when they are expected to agree
  task automatic checkState(input string tag, input logic v, input logic [2:0] c,
                            input logic [7:0] p, input logic ov);
    checkOutput({tag, "/fix.valid"},    8'(bus_fix.valid),    8'(v));
    checkOutput({tag, "/fix.code"},     8'(bus_fix.code),     8'(c));
    checkOutput({tag, "/fix.pending"},  bus_fix.pending,      p);
    checkOutput({tag, "/fix.overflow"}, 8'(bus_fix.overflow), 8'(ov));
    checkOutput({tag, "/rr.valid"},     8'(bus_rr.valid),     8'(v));
    checkOutput({tag, "/rr.code"},      8'(bus_rr.code),      8'(c));
    checkOutput({tag, "/rr.pending"},   bus_rr.pending,       p);
    checkOutput({tag, "/rr.overflow"},  8'(bus_rr.overflow),  8'(ov));
  endtask

  // valid plus per-instance code where the two priority modes diverge
  task automatic checkCodes(input string tag, input logic v,
                            input logic [2:0] c_fix, input logic [2:0] c_rr);
    checkOutput({tag, "/fix.valid"}, 8'(bus_fix.valid), 8'(v));
    checkOutput({tag, "/fix.code"},  8'(bus_fix.code),  8'(c_fix));
    checkOutput({tag, "/rr.valid"},  8'(bus_rr.valid),  8'(v));
    checkOutput({tag, "/rr.code"},   8'(bus_rr.code),   8'(c_rr));
  endtask

  // Two cycles of reset with the given event lines, then release
  task automatic doReset(input logic [7:0] ev);
    rst_n = 1'b0;
    applyStimulus(ev, 1'b0, 1'b0);
    tick();
    tick();
    checkState("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Single pulse on line 5 with the consumer always ready
    doReset(8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    applyStimulus(8'h20, 1'b1, 1'b0); tick();
    checkState("t1_capture", 1'b0, 3'd0, 8'h20, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkState("t1_present", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    checkState("t1_done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Lines 3,1,0 together, back-to-back transfers, then lines 7 and 0
    doReset(8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    applyStimulus(8'h0B, 1'b1, 1'b0); tick();
    checkState("t2_capture", 1'b0, 3'd0, 8'h0B, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkState("t2_code3", 1'b1, 3'd3, 8'h0B, 1'b0);
    tick();
    checkState("t2_code1", 1'b1, 3'd1, 8'h03, 1'b0);
    tick();
    checkState("t2_code0", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    checkState("t2_idle", 1'b0, 3'd0, 8'h00, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0); tick();
    checkState("t2b_capture", 1'b0, 3'd0, 8'h81, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkState("t2b_code7", 1'b1, 3'd7, 8'h81, 1'b0);
    tick();
    checkState("t2b_code0", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    checkState("t2b_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // Line 7 arrives while 3 waits: fixed goes 7,1,0, round-robin 1,0,7
    doReset(8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    applyStimulus(8'h0B, 1'b0, 1'b0); tick();
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    checkState("t3_code3", 1'b1, 3'd3, 8'h0B, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0); tick();
    checkState("t3_late7", 1'b1, 3'd3, 8'h8B, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkCodes("t3_second", 1'b1, 3'd7, 3'd1);
    tick();
    checkCodes("t3_third", 1'b1, 3'd1, 3'd0);
    tick();
    checkCodes("t3_fourth", 1'b1, 3'd0, 3'd7);
    tick();
    checkCodes("t3_idle", 1'b0, 3'd0, 3'd0);

    // Code 6 held under back-pressure while line 6 rises again
    doReset(8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    applyStimulus(8'h40, 1'b0, 1'b0); tick();
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    checkState("t4_present", 1'b1, 3'd6, 8'h40, 1'b0);
    tick();
    checkState("t4_hold", 1'b1, 3'd6, 8'h40, 1'b0);
    applyStimulus(8'h40, 1'b0, 1'b0); tick();
    checkState("t4_ovf", 1'b1, 3'd6, 8'h40, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    checkState("t4_ovf_gone", 1'b1, 3'd6, 8'h40, 1'b0);
    tick();
    checkState("t4_hold_more", 1'b1, 3'd6, 8'h40, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkState("t4_xfer", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    checkState("t4_single", 1'b0, 3'd0, 8'h00, 1'b0);

    // Line 2 rises in the very cycle code 2 is taken
    doReset(8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    applyStimulus(8'h04, 1'b0, 1'b0); tick();
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    checkState("t5_present", 1'b1, 3'd2, 8'h04, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0); tick();
    checkState("t5_retake", 1'b0, 3'd0, 8'h04, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); tick();
    checkState("t5_again", 1'b1, 3'd2, 8'h04, 1'b0);
    tick();
    checkState("t5_done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Lines held high through reset release, then a flush with a rise
    doReset(8'hFF);
    applyStimulus(8'hFF, 1'b0, 1'b0); tick();
    checkState("t6_held", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    checkState("t6_held2", 1'b0, 3'd0, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    applyStimulus(8'h44, 1'b0, 1'b0); tick();
    checkState("t6_capture", 1'b0, 3'd0, 8'h44, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); tick();
    checkState("t6_present", 1'b1, 3'd6, 8'h44, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b1); tick();
    checkState("t6_clear", 1'b0, 3'd0, 8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0); tick();
    checkState("t6_after", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    checkState("t6_still", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
